// File: rtl/rdmap_ddr_wr_arbiter.sv
// Round-robin arbiter sharing the DDR write channel: grants whole bursts, streams the
// data beats into the data FIFO, then writes the paired command descriptor.
//   state | meaning
//   IDLE  | no burst owned; pick next requester round-robin from last_grant+1
//   DATA  | stream BEATS beats from the granted requester into the data FIFO
//   CMD   | wait for command FIFO room, write the latched descriptor once
module rdmap_ddr_wr_arbiter #(
  parameter int N_REQ  = 2,
  parameter int BEATS  = 256,
  parameter int DATA_W = 128,
  parameter int CMD_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        s_cmd_valid,
  input  logic [N_REQ*CMD_W-1:0]  s_cmd_data,
  output logic [N_REQ-1:0]        s_cmd_ready,
  input  logic [N_REQ-1:0]        s_data_valid,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  output logic [N_REQ-1:0]        s_data_ready,
  output logic [N_REQ-1:0]        s_done,
  output logic [DATA_W-1:0]       fifo_din_wr_rdmap,
  output logic                    fifo_wr_en_wr_rdmap,
  input  logic                    fifo_full_wr_rdmap,
  output logic [CMD_W-1:0]        fifo_din_cmd_rdmap,
  output logic                    fifo_wr_en_cmd_rdmap,
  input  logic                    fifo_full_cmd_rdmap,
  output logic [1:0]              grant_idx,
  output logic                    busy
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CMD} state_t;

  state_t             state, state_nxt;
  logic [1:0]         g, g_nxt, last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [CMD_W-1:0]   cmd_reg, cmd_reg_nxt, cmd_din_nxt, rr_cmd;
  logic [DATA_W-1:0]  data_din_nxt, data_sel;
  logic [N_REQ-1:0]   cmd_ready_nxt, done_nxt;
  logic               data_wr_nxt, cmd_wr_nxt, valid_sel, any_req;
  logic [1:0]         rr_sel;

  // Descending offset scan so the smallest offset from last_grant+1 wins.
  always_comb begin
    any_req = 1'b0;
    rr_sel  = last_grant;
    rr_cmd  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i == (int'(last_grant) + k) % N_REQ && s_cmd_valid[i]) begin
          any_req = 1'b1;
          rr_sel  = 2'(i);
          rr_cmd  = s_cmd_data[i*CMD_W +: CMD_W];
        end
      end
    end
  end

  always_comb begin
    data_sel     = '0;
    valid_sel    = 1'b0;
    s_data_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g == 2'(i)) begin
        data_sel  = s_data[i*DATA_W +: DATA_W];
        valid_sel = s_data_valid[i];
        s_data_ready[i] = (state == ST_DATA) && !fifo_full_wr_rdmap;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    g_nxt          = g;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    cmd_reg_nxt    = cmd_reg;
    cmd_ready_nxt  = '0;
    done_nxt       = '0;
    data_wr_nxt    = 1'b0;
    data_din_nxt   = fifo_din_wr_rdmap;
    cmd_wr_nxt     = 1'b0;
    cmd_din_nxt    = fifo_din_cmd_rdmap;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          g_nxt        = rr_sel;
          cmd_reg_nxt  = rr_cmd;
          beat_cnt_nxt = '0;
          state_nxt    = ST_DATA;
          for (int i = 0; i < N_REQ; i++)
            if (rr_sel == 2'(i)) cmd_ready_nxt[i] = 1'b1;
        end
      end
      ST_DATA: begin
        if (valid_sel && !fifo_full_wr_rdmap) begin
          data_wr_nxt  = 1'b1;
          data_din_nxt = data_sel;
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = ST_CMD;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (!fifo_full_cmd_rdmap) begin
          cmd_wr_nxt     = 1'b1;
          cmd_din_nxt    = cmd_reg;
          last_grant_nxt = g;
          state_nxt      = ST_IDLE;
          for (int i = 0; i < N_REQ; i++)
            if (g == 2'(i)) done_nxt[i] = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      g                    <= '0;
      last_grant           <= 2'(N_REQ - 1);
      beat_cnt             <= '0;
      cmd_reg              <= '0;
      s_cmd_ready          <= '0;
      s_done               <= '0;
      fifo_wr_en_wr_rdmap  <= 1'b0;
      fifo_din_wr_rdmap    <= '0;
      fifo_wr_en_cmd_rdmap <= 1'b0;
      fifo_din_cmd_rdmap   <= '0;
    end else begin
      state                <= state_nxt;
      g                    <= g_nxt;
      last_grant           <= last_grant_nxt;
      beat_cnt             <= beat_cnt_nxt;
      cmd_reg              <= cmd_reg_nxt;
      s_cmd_ready          <= cmd_ready_nxt;
      s_done               <= done_nxt;
      fifo_wr_en_wr_rdmap  <= data_wr_nxt;
      fifo_din_wr_rdmap    <= data_din_nxt;
      fifo_wr_en_cmd_rdmap <= cmd_wr_nxt;
      fifo_din_cmd_rdmap   <= cmd_din_nxt;
    end
  end

  assign grant_idx = g;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rdmap_ddr_wr_arbiter.sv
// Scoreboard bench: requester drivers, a round-robin burst-order model feeding an
// expected-write queue, and a monitor popping it on every FIFO write.
module tb_rdmap_ddr_wr_arbiter;
  localparam int N   = 2;
  localparam int BTS = 256;
  localparam int DW  = 128;
  localparam int CW  = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_cmd_valid, s_cmd_ready, s_data_valid, s_data_ready, s_done;
  logic [N*CW-1:0] s_cmd_data;
  logic [N*DW-1:0] s_data;
  logic [DW-1:0]   fifo_din_wr_rdmap;
  logic            fifo_wr_en_wr_rdmap, fifo_full_wr_rdmap;
  logic [CW-1:0]   fifo_din_cmd_rdmap;
  logic            fifo_wr_en_cmd_rdmap, fifo_full_cmd_rdmap;
  logic [1:0]      grant_idx;
  logic            busy;

  rdmap_ddr_wr_arbiter #(.N_REQ(N), .BEATS(BTS), .DATA_W(DW), .CMD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_valid(s_cmd_valid), .s_cmd_data(s_cmd_data), .s_cmd_ready(s_cmd_ready),
    .s_data_valid(s_data_valid), .s_data(s_data), .s_data_ready(s_data_ready),
    .s_done(s_done),
    .fifo_din_wr_rdmap(fifo_din_wr_rdmap), .fifo_wr_en_wr_rdmap(fifo_wr_en_wr_rdmap),
    .fifo_full_wr_rdmap(fifo_full_wr_rdmap),
    .fifo_din_cmd_rdmap(fifo_din_cmd_rdmap), .fifo_wr_en_cmd_rdmap(fifo_wr_en_cmd_rdmap),
    .fifo_full_cmd_rdmap(fifo_full_cmd_rdmap),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_cmd; int id; logic [127:0] val; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cmd_cnt = 0;

  // stimulus control (main writes, driver reads)
  int          req_seq[N];
  logic [63:0] cmd_word[N];
  int          burst_id[N];
  int          mode[N];
  bit          full_wr_force, full_wr_rand, full_cmd_force, full_cmd_rand;
  // driver state
  int          seen_seq[N];
  int          left[N];
  int          beat_idx[N];
  int          cyc[N];
  logic [N-1:0] last_xfer;
  int          model_last = N - 1;
  int          burst_ctr = 0;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [127:0] beat_val(input int r, input int b, input int k);
    return {32'(r), 32'(b), 64'(k)};
  endfunction

  // requester drivers and FIFO-full generators
  initial begin
    s_cmd_valid = '0; s_data_valid = '0; s_cmd_data = '0; s_data = '0;
    fifo_full_wr_rdmap = 1'b0; fifo_full_cmd_rdmap = 1'b0; last_xfer = '0;
    for (int i = 0; i < N; i++) begin seen_seq[i] = 0; left[i] = 0; beat_idx[i] = 0; cyc[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_cmd_valid = '0; s_data_valid = '0; last_xfer = '0;
        fifo_full_wr_rdmap = 1'b0; fifo_full_cmd_rdmap = 1'b0;
        for (int i = 0; i < N; i++) begin seen_seq[i] = req_seq[i]; left[i] = 0; end
      end else begin
        chk(fifo_wr_en_wr_rdmap == (|last_xfer), "wr_en_mirror", fifo_wr_en_wr_rdmap, |last_xfer);
        for (int i = 0; i < N; i++) begin
          if (last_xfer[i]) begin beat_idx[i]++; left[i]--; end
          if (s_cmd_ready[i]) s_cmd_valid[i] = 1'b0;
          if (req_seq[i] != seen_seq[i]) begin
            seen_seq[i] = req_seq[i];
            s_cmd_valid[i] = 1'b1;
            s_cmd_data[i*CW +: CW] = cmd_word[i];
            left[i] = BTS; beat_idx[i] = 0; cyc[i] = 0;
          end
          case (mode[i])
            1:       s_data_valid[i] = (left[i] > 0) && ($urandom_range(0, 3) != 0);
            2:       s_data_valid[i] = (left[i] > 0) && (cyc[i] % 3 != 2);
            default: s_data_valid[i] = (left[i] > 0);
          endcase
          s_data[i*DW +: DW] = beat_val(i, burst_id[i], beat_idx[i]);
          cyc[i]++;
        end
        fifo_full_wr_rdmap  = full_wr_force  || (full_wr_rand  && $urandom_range(0, 3) == 0);
        fifo_full_cmd_rdmap = full_cmd_force || (full_cmd_rand && $urandom_range(0, 3) == 0);
        #1;
        last_xfer = s_data_valid & s_data_ready;
        if (fifo_full_wr_rdmap) chk(s_data_ready == '0, "ready_when_full", s_data_ready, 0);
      end
    end
  end

  // monitor: pop and compare on every FIFO write
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fifo_wr_en_wr_rdmap) begin
          chk(exp_q.size() > 0, "data_expected", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(!e.is_cmd, "data_before_cmd", fifo_din_wr_rdmap, e.val);
            chk(fifo_din_wr_rdmap == e.val, "data_beat", fifo_din_wr_rdmap, e.val);
          end
        end
        if (fifo_wr_en_cmd_rdmap) begin
          cmd_cnt++;
          chk(exp_q.size() > 0, "cmd_expected", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.is_cmd, "cmd_after_beats", exp_q.size(), 0);
            chk(fifo_din_cmd_rdmap == e.val[63:0], "cmd_word", fifo_din_cmd_rdmap, e.val);
            chk(s_done == N'(1 << e.id), "done_pulse", s_done, 1 << e.id);
            chk(grant_idx == 2'(e.id), "grant_idx", grant_idx, e.id);
          end
        end else begin
          chk(s_done == '0, "done_idle", s_done, 0);
        end
      end
    end
  end

  task automatic cyc_wait();
    @(posedge clk); #1;
  endtask

  // round-robin burst order model: whole bursts, next pending after the last served
  task automatic issue(input logic [N-1:0] set, input logic [63:0] fixed, input bit use_fixed);
    logic [N-1:0] pend = set;
    for (int i = 0; i < N; i++) if (set[i]) begin
      burst_ctr++;
      burst_id[i] = burst_ctr;
      cmd_word[i] = use_fixed ? fixed : {$urandom, $urandom};
    end
    while (pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (model_last + k) % N;
        if (pend[idx]) begin
          for (int b = 0; b < BTS; b++) exp_q.push_back('{1'b0, idx, beat_val(idx, burst_id[idx], b)});
          exp_q.push_back('{1'b1, idx, {64'd0, cmd_word[idx]}});
          pend[idx] = 1'b0;
          model_last = idx;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) if (set[i]) req_seq[i]++;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin cyc_wait(); n++; end
    chk(n < max, nm, n, max);
    if (n >= max) exp_q.delete();
  endtask

  task automatic wait_beat(input int r, input int b);
    int n = 0;
    while (beat_idx[r] < b && n < 2000) begin cyc_wait(); n++; end
    chk(n < 2000, "beat_reached", beat_idx[r], b);
  endtask

  initial begin
    int c0, n;
    rst_n = 1'b0;
    full_wr_force = 0; full_wr_rand = 0; full_cmd_force = 0; full_cmd_rand = 0;
    for (int i = 0; i < N; i++) begin req_seq[i] = 0; cmd_word[i] = '0; burst_id[i] = 0; mode[i] = 0; end
    repeat (3) cyc_wait();
    chk(busy == 0, "rst_busy", busy, 0);
    chk(grant_idx == 0, "rst_grant", grant_idx, 0);
    chk({fifo_wr_en_wr_rdmap, fifo_wr_en_cmd_rdmap} == 0, "rst_wr_en", {fifo_wr_en_wr_rdmap, fifo_wr_en_cmd_rdmap}, 0);
    chk({s_cmd_ready, s_data_ready, s_done} == 0, "rst_handshake", {s_cmd_ready, s_data_ready, s_done}, 0);
    chk(fifo_din_wr_rdmap == 0 && fifo_din_cmd_rdmap == 0, "rst_din", fifo_din_cmd_rdmap, 0);
    rst_n = 1'b1;
    cyc_wait();

    // simultaneous requests, twice: req0, req1, req0, req1
    issue(2'b11, 64'd0, 1'b0);
    wait_idle(3000, "simul_round1");
    issue(2'b11, 64'd0, 1'b0);
    wait_idle(3000, "simul_round2");

    // single burst with fixed descriptor and grant latency
    issue(2'b01, 64'h0000_0000_8000_0FFF, 1'b1);
    cyc_wait();
    chk(s_cmd_ready == 2'b01, "cmd_ready_latency", s_cmd_ready, 1);
    cyc_wait();
    chk(s_cmd_ready == 2'b00, "cmd_ready_pulse", s_cmd_ready, 0);
    chk(busy == 1, "busy_in_burst", busy, 1);
    wait_idle(2000, "single_burst");
    chk(busy == 0, "busy_after", busy, 0);

    // data backpressure window at beat 100
    issue(2'b01, 64'd0, 1'b0);
    wait_beat(0, 100);
    full_wr_force = 1;
    repeat (10) cyc_wait();
    full_wr_force = 0;
    wait_idle(2000, "data_backpressure");

    // command backpressure: 20 cycles held in CMD
    full_cmd_force = 1;
    c0 = cmd_cnt;
    issue(2'b10, 64'd0, 1'b0);
    n = 0;
    while (exp_q.size() != 1 && n < 2000) begin cyc_wait(); n++; end
    chk(n < 2000, "last_beat_landed", exp_q.size(), 1);
    repeat (20) begin
      cyc_wait();
      chk(busy == 1 && fifo_wr_en_cmd_rdmap == 0, "cmd_held", {busy, fifo_wr_en_cmd_rdmap}, 2'b10);
    end
    full_cmd_force = 0;
    cyc_wait();
    chk(fifo_wr_en_cmd_rdmap == 1, "cmd_after_release", fifo_wr_en_cmd_rdmap, 1);
    wait_idle(100, "cmd_backpressure");
    chk(cmd_cnt - c0 == 1, "cmd_single_pulse", cmd_cnt - c0, 1);

    // asynchronous reset mid-burst
    issue(2'b01, 64'd0, 1'b0);
    wait_beat(0, 50);
    rst_n = 1'b0;
    #1;
    chk({fifo_wr_en_wr_rdmap, fifo_wr_en_cmd_rdmap, busy} == 0, "async_rst_en",
        {fifo_wr_en_wr_rdmap, fifo_wr_en_cmd_rdmap, busy}, 0);
    chk(fifo_din_wr_rdmap == 0 && fifo_din_cmd_rdmap == 0, "async_rst_din", fifo_din_wr_rdmap, 0);
    chk({s_cmd_ready, s_data_ready, s_done, grant_idx} == 0, "async_rst_hs",
        {s_cmd_ready, s_data_ready, s_done, grant_idx}, 0);
    exp_q.delete();
    model_last = N - 1;
    repeat (3) cyc_wait();
    rst_n = 1'b1;
    cyc_wait();
    c0 = cmd_cnt;
    issue(2'b10, 64'd0, 1'b0);
    wait_idle(2000, "post_reset_burst");
    chk(cmd_cnt - c0 == 1, "post_reset_cmds", cmd_cnt - c0, 1);
    chk(grant_idx == 2'd1, "post_reset_grant", grant_idx, 1);

    // bursty valid on req1
    mode[1] = 2;
    issue(2'b10, 64'd0, 1'b0);
    wait_idle(2000, "bursty_valid");
    mode[1] = 0;

    // randomized rounds
    repeat (8) begin
      logic [N-1:0] set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) mode[i] = $urandom_range(0, 2);
      full_wr_rand  = bit'($urandom_range(0, 1));
      full_cmd_rand = bit'($urandom_range(0, 1));
      issue(set, 64'd0, 1'b0);
      wait_idle(5000, "random_round");
      full_wr_rand = 0; full_cmd_rand = 0;
    end

    repeat (3) cyc_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
